mux_share_arbiter: RTL
======================

# mux_share_arbiter

Round-robin arbiter that shares the 32-bit 2:1 select datapath between two burst requesters and a single downstream consumer. It owns the select line, issues registered grants, and holds a grant for a whole burst, which is delimited by `last`. Downstream flow uses valid/ready. It sits in front of the shared operand/bus mux in the CPU datapath.

## Interface
- `WIDTH`, 32: data width of each requester and of the output.
- `MAX_BURST`, 4: maximum beats per grant; used only when `ARB_BURST_LIMIT_EN` is defined. Legal range 1–15.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `req0` / `req1`, input, 1: requester has a beat available.
- `last0` / `last1`, input, 1: the current beat is the final beat of the burst. Sampled only on a transfer.
- `data0` / `data1`, input, WIDTH: requester beat data.
- `gnt0` / `gnt1`, output, 1: registered grant. One-hot or both zero.
- `out_sel`, output, 1: registered mux select. 0 selects requester 0, 1 selects requester 1.
- `out_valid`, output, 1: downstream beat valid.
- `out_ready`, input, 1: downstream accepts the beat.
- `out_data`, output, WIDTH: the selected requester's data.
- `out_last`, output, 1: the selected requester's `last`.

## Operation
- **States:**
  - IDLE: no grant.
  - OWN0: requester 0 holds the grant.
  - OWN1: requester 1 holds the grant.
- **Priority pointer:** `ptr`, reset 0, means requester 0 is preferred first.
- **Arbitration decision** (made in IDLE, or at the release point):
  - Only one `req` high: grant that requester.
  - Both high: grant the requester named by `ptr`.
  - Neither high: go to IDLE.
- **Pointer update:** on every new grant to requester k, `ptr` becomes !k. Round-robin fairness follows from this.
- **Outputs while owning:**
  - In OWNk: `out_valid = reqk`, `out_data = datak`, `out_last = lastk`.
  - `out_data`, `out_last` and `out_valid` are combinational from the owner's inputs through the registered `out_sel`.
  - In IDLE: `out_valid = 0`, `out_last = 0`. `out_data` follows the data input selected by `out_sel`.
- **Transfer:** occurs when `out_valid && out_ready`.
- **Release:** occurs on a transfer with `out_last = 1`. The next owner is decided in the same cycle by the arbitration rule and takes effect at the next edge, so there is zero bubble between bursts.
- **Lock:** the owner keeps the grant while it deasserts `req` mid-burst. `out_valid` is low during those cycles. The other requester waits.
- **Reset:** asserting `rst_n` low at any time, including mid-burst, immediately drives:
  - `gnt0`/`gnt1`/`out_sel`/`out_valid` = 0
  - state = IDLE, `ptr` = 0, beat counter = 0
  
  Any partially transferred burst is abandoned.
- **Unchanged by `out_ready`:** grant state is unaffected while `out_ready` is low; a beat is simply held.

## Timing
- **Arbitration latency:** `req` rising in IDLE at edge N produces `gnt`/`out_sel` at edge N+1. The first beat can transfer in the cycle after edge N+1.
- **Handover:** when the last beat transfers in the cycle before edge M and another request is pending, the new grant appears at edge M.
- **Combinational paths:** `out_valid` and `out_data` reach the consumer in the same cycle as the owner's `req`/`data`. The arbiter has no combinational path from `out_ready` to `gnt`.
- **Grant encoding:** `gnt0` and `gnt1` are never high together, and `out_sel` always equals `gnt1` whenever a grant is held.

## Configuration
- **`ARB_BURST_LIMIT_EN` defined:**
  - A 4-bit beat counter increments on each transfer and clears on release.
  - Release is forced on the transfer that makes the count equal `MAX_BURST`, even with `last = 0`.
  - The requester must re-arbitrate for the remainder of its burst.
- **`ARB_BURST_LIMIT_EN` undefined:**
  - No counter is built.
  - Release happens only on `last`, so bursts are unbounded.

## Test plan
1. **Reset values:** hold `rst_n` low 3 cycles, then release with `req0 = req1 = 0`.
   - Required: `gnt0 = gnt1 = 0`, `out_valid = 0`, `out_sel = 0`, and all stay 0.
2. **Tie and handover:** `req0 = req1 = 1` asserted together in IDLE, single-beat bursts (`last = 1`), `out_ready = 1`.
   - Required: `gnt0` one cycle later; `out_data = data0 = 32'hAAAA_0000`.
   - Next cycle: `gnt1`, `out_data = 32'h5555_0001`.
   - Grants then alternate 0,1,0,1 with no idle cycle.
3. **Lock during a gap:** owner 0 runs a 3-beat burst, drops `req0` for 2 cycles after beat 1, while `req1 = 1` throughout.
   - Required: `gnt0` held; `out_valid = 0` during the gap; `gnt1` only after beat 3 with `last0 = 1`.
4. **Backpressure:** hold `out_ready = 0` for 5 cycles during OWN1.
   - Required: `out_valid = 1`, and `out_data` and `gnt1` stay stable.
   - No transfer is counted and no release occurs until `out_ready = 1`.
5. **Reset mid-burst:** pulse `rst_n` low asynchronously in the middle of beat 2 of a burst from requester 1.
   - Required: `gnt1` drops without waiting for a clock edge.
   - After reset, arbitration restarts with `ptr = 0`: with both requesting, `gnt0` comes first.
6. **Burst limit (`ARB_BURST_LIMIT_EN` defined, `MAX_BURST = 4`):** requester 0 sends a 6-beat burst while `req1 = 1`.
   - Required: forced release after beat 4; requester 1 is granted next; requester 0 regains the grant afterwards for beats 5–6.
   - With the macro undefined, all 6 beats transfer consecutively.

Source files
------------

// File: rtl/mux_share_arbiter.sv
// Round-robin burst arbiter owning the select of a shared 2:1 WIDTH-bit mux.
// Optional per-grant beat cap enabled by defining ARB_BURST_LIMIT_EN (uses MAX_BURST).

module mux_share_arbiter_lane (
  input  logic gnt_i,
  input  logic req_i,
  input  logic last_i,
  output logic vld_o,
  output logic last_o
);
  assign vld_o  = gnt_i & req_i;
  assign last_o = gnt_i & last_i;
endmodule

module mux_share_arbiter #(
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic             last0,
  input  logic             last1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             out_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_e;

  state_e     state_q;
  logic       ptr_q, gnt0_q, gnt1_q, sel_q;
  logic [1:0] gnt_v, req_v, lastin_v, vld_v, last_v;
  logic       xfer, rel, arb_en, pick_vld_d, pick_d;

  assign gnt_v    = {gnt1_q, gnt0_q};
  assign req_v    = {req1, req0};
  assign lastin_v = {last1, last0};

  for (genvar i = 0; i < 2; i++) begin : g_lane
    mux_share_arbiter_lane u_lane (
      .gnt_i (gnt_v[i]),
      .req_i (req_v[i]),
      .last_i(lastin_v[i]),
      .vld_o (vld_v[i]),
      .last_o(last_v[i])
    );
  end

  assign out_valid = |vld_v;
  assign out_last  = |last_v;
  assign out_data  = sel_q ? data1 : data0;
  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign out_sel   = sel_q;

  assign xfer = out_valid & out_ready;

`ifdef ARB_BURST_LIMIT_EN
  localparam logic [3:0] MAXB = 4'(MAX_BURST);
  logic [3:0] cnt_q;
  logic       limit_hit;

  // Force a handover on the beat that fills the cap, regardless of last.
  assign limit_hit = (cnt_q + 4'd1) == MAXB;
  assign rel       = xfer & (out_last | limit_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt_q <= 4'd0;
    else if (rel)  cnt_q <= 4'd0;
    else if (xfer) cnt_q <= cnt_q + 4'd1;
  end
`else
  localparam logic [3:0] MAXB = 4'(MAX_BURST);
  logic unused_maxb;
  assign unused_maxb = ^MAXB;
  assign rel = xfer & out_last;
`endif

  // Ties go to ptr_q; a lone requester wins outright.
  assign arb_en     = (state_q == IDLE) | rel;
  assign pick_vld_d = req0 | req1;
  assign pick_d     = (req0 & req1) ? ptr_q : req1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      sel_q   <= 1'b0;
    end else if (arb_en) begin
      if (pick_vld_d) begin
        state_q <= pick_d ? OWN1 : OWN0;
        gnt0_q  <= ~pick_d;
        gnt1_q  <= pick_d;
        sel_q   <= pick_d;
        ptr_q   <= ~pick_d;
      end else begin
        state_q <= IDLE;
        gnt0_q  <= 1'b0;
        gnt1_q  <= 1'b0;
      end
    end
  end

endmodule
